sdram_port_arbiter: RTL and testbench

Two-port scheduler in front of `memory_controller`: it accepts single-word read/write requests from two independent requesters and picks one per access, round-robin by default. It sequences the winner onto the controller's host port using the row-cycle, column-cycle, wait protocol, then returns completion and read data. It sits between the system masters and `memory_controller`, so the controller sees exactly one host.

---
 rtl/sdram_port_arbiter_pkg.sv | 25 ++
 rtl/sdram_port_arbiter_rr_pick_2.sv | 29 ++
 rtl/sdram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared widths, FSM state encoding and latched-command record for the
// two-port SDRAM arbiter.
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_W = 13;
  localparam int SDRAM_BANK_W = 2;
  localparam int SDRAM_COL_W  = 9;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ROW,
    COL,
    WAIT
  } arb_state_t;

  typedef struct packed {
    logic                    we;
    logic [SDRAM_BANK_W-1:0] bank;
    logic [SDRAM_ADDR_W-1:0] row;
    logic [SDRAM_COL_W-1:0]  col;
    logic [SDRAM_DATA_W-1:0] wdata;
  } sdram_cmd_t;

endpackage

// File: rtl/sdram_port_arbiter_rr_pick_2.sv
// Two-requester winner select. Round-robin on ties by default; with
// ARB_FIXED_PRIO_EN defined, port 0 always wins a tie.
module rr_pick_2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

  // One-hot winner; a tie goes to the port not granted last.
  always_comb begin
    pick_o = '0;
    unique case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
`ifdef ARB_FIXED_PRIO_EN
      2'b11:   pick_o = 2'b01;
`else
      2'b11:   pick_o = last_i ? 2'b01 : 2'b10;
`endif
      default: pick_o = '0;
    endcase
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port request scheduler in front of memory_controller. Sequences the
// winning request through ROW, COL, WAIT and returns DONE/RVALID/RDATA.
// Optional build macro: ARB_FIXED_PRIO_EN (port 0 strict priority on ties).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = SDRAM_ADDR_W,
  parameter int BANK_W   = SDRAM_BANK_W,
  parameter int COL_W    = SDRAM_COL_W,
  parameter int DATA_W   = SDRAM_DATA_W,
  parameter int WAIT_CYC = 3
) (
  input  logic                CLK,
  input  logic                NRST,
  input  logic [1:0]          REQ,
  input  logic [1:0]          REQ_WE,
  input  logic [2*BANK_W-1:0] REQ_BANK,
  input  logic [2*ADDR_W-1:0] REQ_ROW,
  input  logic [2*COL_W-1:0]  REQ_COL,
  input  logic [2*DATA_W-1:0] REQ_WDATA,
  output logic [1:0]          GNT,
  output logic [1:0]          DONE,
  output logic [1:0]          RVALID,
  output logic [DATA_W-1:0]   RDATA,
  input  logic                MC_RDY,
  output logic [ADDR_W-1:0]   MC_ADR,
  output logic [BANK_W-1:0]   MC_BDR,
  output logic [DATA_W-1:0]   MC_DIN,
  input  logic [DATA_W-1:0]   MC_DOUT,
  output logic                MC_WE,
  output logic                MC_RE
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  arb_state_t        state_q, state_d;
  sdram_cmd_t        cmd_q, cmd_d, req_cmd;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        pick;

  rr_pick_2 u_pick (
    .req_i  (REQ),
    .last_i (last_q),
    .pick_o (pick)
  );

  // Fields of the port the picker selected, ready to be latched on grant.
  always_comb begin
    req_cmd.we    = REQ_WE[pick[1]];
    req_cmd.bank  = pick[1] ? REQ_BANK[2*BANK_W-1:BANK_W]   : REQ_BANK[BANK_W-1:0];
    req_cmd.row   = pick[1] ? REQ_ROW[2*ADDR_W-1:ADDR_W]    : REQ_ROW[ADDR_W-1:0];
    req_cmd.col   = pick[1] ? REQ_COL[2*COL_W-1:COL_W]      : REQ_COL[COL_W-1:0];
    req_cmd.wdata = pick[1] ? REQ_WDATA[2*DATA_W-1:DATA_W]  : REQ_WDATA[DATA_W-1:0];
  end

  // Next-state, grant/completion pulses and wait counter.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    win_d    = win_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (MC_RDY && (pick != 2'b00)) begin
          cmd_d   = req_cmd;
          win_d   = pick[1];
          last_d  = pick[1];
          gnt_d   = pick;
          state_d = ROW;
        end
      end
      ROW: state_d = COL;
      COL: begin
        cnt_d   = CW'(WAIT_CYC - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (MC_RDY) begin
          done_d = {win_q, ~win_q};
          if (!cmd_q.we) begin
            rvalid_d = {win_q, ~win_q};
            rdata_d  = MC_DOUT;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      win_q    <= win_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Controller drive is decoded from registered state, so address, bank and
  // data hold from COL through WAIT and idle without extra registers.
  assign MC_ADR = (state_q == ROW) ? cmd_q.row : ADDR_W'(cmd_q.col);
  assign MC_BDR = cmd_q.bank;
  assign MC_DIN = cmd_q.wdata;
  assign MC_WE  = ((state_q == ROW) || (state_q == COL)) &&  cmd_q.we;
  assign MC_RE  = ((state_q == ROW) || (state_q == COL)) && !cmd_q.we;

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  logic        CLK = 1'b0;
  logic        NRST;
  logic [1:0]  REQ;
  logic [1:0]  REQ_WE;
  logic [3:0]  REQ_BANK;
  logic [25:0] REQ_ROW;
  logic [17:0] REQ_COL;
  logic [31:0] REQ_WDATA;
  logic [1:0]  GNT, DONE, RVALID;
  logic [15:0] RDATA;
  logic        MC_RDY;
  logic [12:0] MC_ADR;
  logic [1:0]  MC_BDR;
  logic [15:0] MC_DIN;
  logic [15:0] MC_DOUT;
  logic        MC_WE, MC_RE;

  sdram_port_arbiter #(
    .ADDR_W  (13),
    .BANK_W  (2),
    .COL_W   (9),
    .DATA_W  (16),
    .WAIT_CYC(3)
  ) dut (
    .CLK(CLK), .NRST(NRST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_BANK(REQ_BANK),
    .REQ_ROW(REQ_ROW), .REQ_COL(REQ_COL), .REQ_WDATA(REQ_WDATA),
    .GNT(GNT), .DONE(DONE), .RVALID(RVALID), .RDATA(RDATA),
    .MC_RDY(MC_RDY), .MC_ADR(MC_ADR), .MC_BDR(MC_BDR), .MC_DIN(MC_DIN),
    .MC_DOUT(MC_DOUT), .MC_WE(MC_WE), .MC_RE(MC_RE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  port_oh;
    logic        rd;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic tb_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_pick(input logic [1:0] r);
    logic [1:0] w;
    if (r == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
      w = 2'b01;
`else
      w = tb_last ? 2'b01 : 2'b10;
`endif
    end else begin
      w = r;
    end
    if (w != 2'b00) tb_last = (w == 2'b10);
    return w;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [1:0] bank,
                          input logic [12:0] row, input logic [8:0] col,
                          input logic [15:0] data);
    REQ_WE[p]            = we;
    REQ_BANK[p*2 +: 2]   = bank;
    REQ_ROW[p*13 +: 13]  = row;
    REQ_COL[p*9 +: 9]    = col;
    REQ_WDATA[p*16 +: 16] = data;
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp, output int gc);
    int n = 0;
    while (GNT == 2'b00 && n < 50) begin
      tick;
      n++;
    end
    gc = cyc;
    chk({tag, "_gnt"}, 32'(GNT), 32'(exp));
  endtask

  task automatic wait_done(input string tag, input int g, input int lat);
    int n = 0;
    while (DONE == 2'b00 && n < 60) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, cyc - g, lat);
  endtask

  // Scoreboard: every completion must match the oldest expected access.
  always @(negedge CLK) begin
    if (NRST && (DONE != 2'b00 || RVALID != 2'b00)) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_done", 32'(DONE), 32'h0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_done", 32'(DONE), 32'(mon_e.port_oh));
        chk("sb_rvalid", 32'(RVALID), mon_e.rd ? 32'(mon_e.port_oh) : 32'h0);
        if (mon_e.rd) chk("sb_rdata", 32'(RDATA), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int gc, rc, prev, recnt, n;
    logic [1:0] e;

    NRST = 1'b1; REQ = '0; REQ_WE = '0; REQ_BANK = '0; REQ_ROW = '0;
    REQ_COL = '0; REQ_WDATA = '0; MC_RDY = 1'b1; MC_DOUT = '0;
    #2 NRST = 1'b0;
    repeat (3) tick;
    chk("rst_pulses", 32'({GNT, DONE, RVALID}), 32'h0);
    chk("rst_rdata", 32'(RDATA), 32'h0);
    chk("rst_mc_adr", 32'(MC_ADR), 32'h0);
    chk("rst_mc_misc", 32'({MC_BDR, MC_DIN, MC_WE, MC_RE}), 32'h0);
    #3 NRST = 1'b1;
    tick;

    // Port 0 single write
    set_port(0, 1'b1, 2'd1, 13'h005, 9'h1FF, 16'hA5A5);
    REQ = 2'b01; rc = cyc;
    e = model_pick(REQ);
    sbq.push_back('{e, 1'b0, 16'h0});
    wait_gnt("wr", e, gc);
    chk("wr_gnt_lat", gc - rc, 1);
    chk("wr_row_adr", 32'(MC_ADR), 32'h005);
    chk("wr_row_we_re", 32'({MC_WE, MC_RE}), 32'b10);
    chk("wr_row_bdr", 32'(MC_BDR), 32'h1);
    chk("wr_row_din", 32'(MC_DIN), 32'hA5A5);
    REQ = 2'b00;
    tick;
    chk("wr_col_adr", 32'(MC_ADR), 32'h1FF);
    chk("wr_col_we", 32'(MC_WE), 32'h1);
    chk("wr_gnt_pulse", 32'(GNT), 32'h0);
    tick;
    chk("wr_wait_we", 32'(MC_WE), 32'h0);
    chk("wr_wait_adr_hold", 32'(MC_ADR), 32'h1FF);
    wait_done("wr", gc, 5);

    // Port 1 single read
    set_port(1, 1'b0, 2'd2, 13'h0AB, 9'h033, 16'h0000);
    MC_DOUT = 16'h1234;
    REQ = 2'b10;
    e = model_pick(REQ);
    sbq.push_back('{e, 1'b1, 16'h1234});
    wait_gnt("rd", e, gc);
    REQ = 2'b00;
    recnt = 0; n = 0;
    while (DONE == 2'b00 && n < 60) begin
      if (MC_RE) recnt++;
      tick;
      n++;
    end
    chk("rd_re_cycles", recnt, 2);
    chk("rd_lat", cyc - gc, 5);
    chk("rd_rvalid", 32'(RVALID), 32'b10);
    chk("rd_rdata", 32'(RDATA), 32'h1234);
    MC_DOUT = 16'hFFFF;
    tick;
    chk("rd_rvalid_pulse", 32'(RVALID), 32'h0);
    chk("rd_rdata_hold", 32'(RDATA), 32'h1234);

    // Both ports held: alternation (or port 0 only with fixed priority)
    set_port(0, 1'b1, 2'd0, 13'h111, 9'h011, 16'h1111);
    set_port(1, 1'b1, 2'd3, 13'h222, 9'h022, 16'h2222);
    REQ = 2'b11; prev = 0;
    for (int i = 0; i < 4; i++) begin
      e = model_pick(2'b11);
      sbq.push_back('{e, 1'b0, 16'h0});
      wait_gnt($sformatf("tie%0d", i), e, gc);
      if (i > 0) chk("tie_spacing", gc - prev, 6);
      prev = gc;
      if (i == 3) REQ = 2'b00;
      wait_done("tie", gc, 5);
    end

    // MC_RDY low for 10 cycles in WAIT stretches completion
    set_port(0, 1'b1, 2'd3, 13'h1ABC, 9'h0F0, 16'hBEEF);
    REQ = 2'b01;
    e = model_pick(REQ);
    sbq.push_back('{e, 1'b0, 16'h0});
    wait_gnt("stall", e, gc);
    REQ = 2'b00;
    tick;
    tick;
    MC_RDY = 1'b0;
    repeat (10) tick;
    chk("stall_no_done", 32'(DONE), 32'h0);
    MC_RDY = 1'b1;
    wait_done("stall", gc, 13);

    // Reset pulse in COL abandons the access
    set_port(0, 1'b1, 2'd2, 13'h0010, 9'h001, 16'h5555);
    set_port(1, 1'b0, 2'd1, 13'h0020, 9'h002, 16'h0000);
    REQ = 2'b11;
    e = model_pick(2'b11);
    wait_gnt("abort", e, gc);
    tick;
    chk("abort_in_col", 32'(MC_WE | MC_RE), 32'h1);
    #2 NRST = 1'b0;
    #1;
    chk("abort_pulses", 32'({GNT, DONE, RVALID}), 32'h0);
    chk("abort_mc_adr", 32'(MC_ADR), 32'h0);
    chk("abort_mc_misc", 32'({MC_BDR, MC_DIN, MC_WE, MC_RE}), 32'h0);
    chk("abort_rdata", 32'(RDATA), 32'h0);
    #2 NRST = 1'b1;
    tb_last = 1'b1;
    e = model_pick(2'b11);
    sbq.push_back('{e, 1'b0, 16'h0});
    wait_gnt("post_rst", e, gc);
    chk("post_rst_port0", 32'(GNT), 32'b01);
    REQ = 2'b00;
    wait_done("post_rst", gc, 5);

    // MC_RDY low in IDLE blocks grants
    MC_RDY = 1'b0;
    REQ = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("idle_block", 32'({GNT, MC_WE, MC_RE}), 32'h0);
    end
    MC_DOUT = 16'hC3C3;
    MC_RDY = 1'b1;
    e = model_pick(2'b11);
    sbq.push_back('{e, e == 2'b10, 16'hC3C3});
    wait_gnt("unblock", e, gc);
    REQ = 2'b00;
    wait_done("unblock", gc, 5);

    tick;
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
